// File: rtl/risc_isa_pkg.sv
// Shared ISA definitions for the multi-cycle RISC datapath controller:
// opcodes, ALU and PC-source encodings, and the controller state type.
package risc_isa_pkg;

    localparam int OPC_BITS = 6;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_J     = 6'b010000;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_MUL = 3'd5;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode classifier: one-hot class flags plus the ALU
// operation that the EXEC step should request for this opcode.
module opcode_class_decode
    import risc_isa_pkg::*;
(
    input  logic [OPC_BITS-1:0] opc,
    output logic                is_rtype,
    output logic                is_itype,
    output logic                is_load,
    output logic                is_store,
    output logic                is_beqz,
    output logic                is_bneqz,
    output logic                is_jump,
    output logic                is_halt,
    output logic                is_illegal,
    output logic [2:0]          alu_op
);

    always_comb begin
        is_rtype   = 1'b0;
        is_itype   = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_beqz    = 1'b0;
        is_bneqz   = 1'b0;
        is_jump    = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        alu_op     = ALU_ADD;
        unique case (opc)
            OP_ADD:   begin is_rtype = 1'b1; alu_op = ALU_ADD; end
            OP_SUB:   begin is_rtype = 1'b1; alu_op = ALU_SUB; end
            OP_AND:   begin is_rtype = 1'b1; alu_op = ALU_AND; end
            OP_OR:    begin is_rtype = 1'b1; alu_op = ALU_OR;  end
            OP_SLT:   begin is_rtype = 1'b1; alu_op = ALU_SLT; end
            OP_MUL:   begin is_rtype = 1'b1; alu_op = ALU_MUL; end
            OP_ADDI:  begin is_itype = 1'b1; alu_op = ALU_ADD; end
            OP_SUBI:  begin is_itype = 1'b1; alu_op = ALU_SUB; end
            OP_SLTI:  begin is_itype = 1'b1; alu_op = ALU_SLT; end
            OP_LW:    is_load  = 1'b1;
            OP_SW:    is_store = 1'b1;
            OP_BEQZ:  is_beqz  = 1'b1;
            OP_BNEQZ: is_bneqz = 1'b1;
            OP_J:     is_jump  = 1'b1;
            OP_HLT:   is_halt  = 1'b1;
            default:  is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with a req/ready memory
// handshake, latched opcode, sticky halt/illegal and a retire counter.
module multicycle_control_fsm
    import risc_isa_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int OPC_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opc,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_load,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             iord,
    output logic             mem_req,
    output logic             mem_we,
    output logic [2:0]       alu_op,
    output logic             alu_src_b,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t           state;
    state_t           state_n;
    logic [OPC_W-1:0] opc_q;
    logic             retire;
    logic             set_illegal;

    logic       is_rtype, is_itype, is_load, is_store;
    logic       is_beqz, is_bneqz, is_jump, is_halt, is_illegal;
    logic [2:0] dec_alu_op;

    opcode_class_decode u_dec (
        .opc        (opc_q),
        .is_rtype   (is_rtype),
        .is_itype   (is_itype),
        .is_load    (is_load),
        .is_store   (is_store),
        .is_beqz    (is_beqz),
        .is_bneqz   (is_bneqz),
        .is_jump    (is_jump),
        .is_halt    (is_halt),
        .is_illegal (is_illegal),
        .alu_op     (dec_alu_op)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            opc_q   <= '0;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            state <= state_n;
            if (state == S_DECODE)
                opc_q <= opc;
            if (set_illegal)
                illegal <= 1'b1;
            if (retire)
                retired <= retired + CNT_W'(1);
        end
    end

    assign halted = (state == S_HALT);

    always_comb begin
        state_n     = state;
        ir_load     = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_SEQ;
        iord        = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        alu_op      = ALU_ADD;
        alu_src_b   = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        retire      = 1'b0;
        set_illegal = 1'b0;
        unique case (state)
            S_IDLE: state_n = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                    state_n  = S_DECODE;
                end
            end
            S_DECODE: state_n = S_EXEC;
            S_EXEC: begin
                unique case (1'b1)
                    is_rtype: begin
                        alu_op  = dec_alu_op;
                        state_n = S_WB;
                    end
                    is_itype: begin
                        alu_src_b = 1'b1;
                        alu_op    = dec_alu_op;
                        state_n   = S_WB;
                    end
                    is_load, is_store: begin
                        alu_src_b = 1'b1;
                        state_n   = S_MEM;
                    end
                    is_beqz, is_bneqz: begin
                        // zero reflects the tested register during EXEC
                        pc_write = is_beqz ? zero : !zero;
                        pc_src   = PC_BRANCH;
                        retire   = 1'b1;
                        state_n  = S_FETCH;
                    end
                    is_jump: begin
                        pc_write = 1'b1;
                        pc_src   = PC_JUMP;
                        retire   = 1'b1;
                        state_n  = S_FETCH;
                    end
                    is_halt: begin
                        retire  = 1'b1;
                        state_n = S_HALT;
                    end
                    is_illegal: begin
                        set_illegal = 1'b1;
                        state_n     = S_HALT;
                    end
                    default: state_n = S_HALT;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = is_store;
                if (mem_ready) begin
                    retire  = is_store;
                    state_n = is_store ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = is_rtype;
                mem_to_reg = is_load;
                retire     = 1'b1;
                state_n    = S_FETCH;
            end
            S_HALT: state_n = S_HALT;
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized scoreboard bench: a per-instruction timing model pushes the
// expected outputs of every cycle; a negedge monitor pops and compares.
module tb_multicycle_control_fsm;

    typedef struct packed {
        logic        ir_load;
        logic        pc_write;
        logic [1:0]  pc_src;
        logic        iord;
        logic        mem_req;
        logic        mem_we;
        logic [2:0]  alu_op;
        logic        alu_src_b;
        logic        reg_write;
        logic        reg_dst;
        logic        mem_to_reg;
        logic        halted;
        logic        illegal;
        logic [31:0] retired;
    } out_t;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQZ = 4;
    localparam int K_BNEQZ = 5, K_J = 6, K_HLT = 7, K_ILL = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opc = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        ir_load, pc_write, iord, mem_req, mem_we;
    logic        alu_src_b, reg_write, reg_dst, mem_to_reg;
    logic        halted, illegal;
    logic [1:0]  pc_src;
    logic [2:0]  alu_op;
    logic [31:0] retired;

    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n = 0;
    int   model_ret = 0;
    logic model_ill = 1'b0;

    logic [5:0] legal [14] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5,
        6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd16};

    multicycle_control_fsm #(.CNT_W(32), .OPC_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .opc        (opc),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .ir_load    (ir_load),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .iord       (iord),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .alu_op     (alu_op),
        .alu_src_b  (alu_src_b),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .halted     (halted),
        .illegal    (illegal),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    function automatic int kind_of(input logic [5:0] op);
        if (op <= 6'd5) return K_R;
        case (op)
            6'd10, 6'd11, 6'd12: return K_I;
            6'd8:  return K_LW;
            6'd9:  return K_SW;
            6'd14: return K_BEQZ;
            6'd13: return K_BNEQZ;
            6'd16: return K_J;
            6'd63: return K_HLT;
            default: return K_ILL;
        endcase
    endfunction

    function automatic out_t base();
        out_t e = '0;
        e.retired = model_ret;
        e.illegal = model_ill;
        return e;
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [5:0] ro();
        return 6'($urandom);
    endfunction

    task automatic cyc(input logic r, input logic rdy, input logic z,
                       input logic [5:0] o, input out_t e);
        @(posedge clk);
        #1;
        rst = r;
        mem_ready = rdy;
        zero = z;
        opc = o;
        exp_q.push_back(e);
    endtask

    // Previous cycle already drove rst=1, so every cycle here shows IDLE.
    task automatic do_reset(input int n);
        model_ret = 0;
        model_ill = 1'b0;
        for (int i = 0; i < n; i++) cyc(1'b1, rb(), rb(), ro(), base());
        cyc(1'b0, rb(), rb(), ro(), base());
    endtask

    task automatic halt_then_reset(input int n);
        out_t e;
        for (int i = 0; i < n; i++) begin
            e = base();
            e.halted = 1'b1;
            cyc(i == n - 1, rb(), rb(), ro(), e);
        end
        do_reset($urandom_range(0, 2));
    endtask

    // status: 0 retired/normal, 1 aborted by reset, 2 halted
    task automatic run_instr(input logic [5:0] op, input int fw,
                             input int mw, input logic z,
                             input int abort_at, output int status);
        out_t e;
        int k = kind_of(op);
        status = 0;
        for (int i = 0; i < fw; i++) begin
            e = base();
            e.mem_req = 1'b1;
            cyc(1'b0, 1'b0, rb(), ro(), e);
        end
        e = base();
        e.mem_req = 1'b1;
        e.ir_load = 1'b1;
        e.pc_write = 1'b1;
        cyc(1'b0, 1'b1, rb(), ro(), e);
        cyc(1'b0, rb(), rb(), op, base());
        e = base();
        case (k)
            K_R: e.alu_op = op[2:0];
            K_I: begin
                e.alu_src_b = 1'b1;
                e.alu_op = (op == 6'd10) ? 3'd0 : (op == 6'd11) ? 3'd1 : 3'd4;
            end
            K_LW, K_SW: e.alu_src_b = 1'b1;
            K_BEQZ: begin e.pc_write = z; e.pc_src = 2'd1; end
            K_BNEQZ: begin e.pc_write = !z; e.pc_src = 2'd1; end
            K_J: begin e.pc_write = 1'b1; e.pc_src = 2'd2; end
            default: ;
        endcase
        cyc(1'b0, rb(), z, ro(), e);
        if (k >= K_BEQZ && k <= K_HLT) model_ret++;
        if (k == K_ILL) model_ill = 1'b1;
        if (k == K_HLT || k == K_ILL) begin
            status = 2;
            return;
        end
        if (k == K_BEQZ || k == K_BNEQZ || k == K_J) return;
        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i < mw; i++) begin
                e = base();
                e.mem_req = 1'b1;
                e.iord = 1'b1;
                e.mem_we = (k == K_SW);
                cyc(i == abort_at, 1'b0, rb(), ro(), e);
                if (i == abort_at) begin
                    status = 1;
                    return;
                end
            end
            e = base();
            e.mem_req = 1'b1;
            e.iord = 1'b1;
            e.mem_we = (k == K_SW);
            cyc(1'b0, 1'b1, rb(), ro(), e);
            if (k == K_SW) begin
                model_ret++;
                return;
            end
        end
        e = base();
        e.reg_write = 1'b1;
        e.reg_dst = (k == K_R);
        e.mem_to_reg = (k == K_LW);
        cyc(1'b0, rb(), rb(), ro(), e);
        model_ret++;
    endtask

    task automatic step(input logic [5:0] op, input int fw, input int mw,
                        input logic z, input int abort_at);
        int st;
        run_instr(op, fw, mw, z, abort_at, st);
        if (st == 1) do_reset($urandom_range(0, 2));
        if (st == 2) halt_then_reset($urandom_range(1, 4));
    endtask

    initial begin : monitor
        out_t e;
        out_t a;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.ir_load = ir_load;
                a.pc_write = pc_write;
                a.pc_src = pc_src;
                a.iord = iord;
                a.mem_req = mem_req;
                a.mem_we = mem_we;
                a.alu_op = alu_op;
                a.alu_src_b = alu_src_b;
                a.reg_write = reg_write;
                a.reg_dst = reg_dst;
                a.mem_to_reg = mem_to_reg;
                a.halted = halted;
                a.illegal = illegal;
                a.retired = retired;
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got %h want %h (retired got %0d want %0d)",
                             cyc_n, a, e, a.retired, e.retired);
                end
            end
        end
    end

    initial begin : driver
        int r, fw, mw, ab;
        logic [5:0] op;
        repeat (2) @(posedge clk);
        do_reset(3);
        step(6'd0, 0, 0, 1'b0, -1);
        step(6'd8, 2, 3, 1'b0, -1);
        step(6'd14, 0, 0, 1'b1, -1);
        step(6'd14, 0, 0, 1'b0, -1);
        step(6'd13, 0, 0, 1'b0, -1);
        step(6'd16, 0, 0, 1'b0, -1);
        step(6'd9, 0, 3, 1'b0, 1);
        step(6'd1, 1, 0, 1'b0, -1);
        step(6'b110000, 0, 0, 1'b0, -1);
        step(6'd63, 0, 0, 1'b0, -1);
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 99);
            if (r < 3) op = 6'd63;
            else if (r < 5) begin
                do op = ro(); while (kind_of(op) != K_ILL);
            end else op = legal[$urandom_range(0, 13)];
            fw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            mw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            ab = (mw > 0 && $urandom_range(0, 19) == 0) ? $urandom_range(0, mw - 1) : -1;
            step(op, fw, mw, rb(), ab);
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
